// File: rtl/serial_add_seq.sv
// Operand sequencer for a bit-serial adder: feeds A/B LSB-first, owns the carry state, collects the sum.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` port selecting A-B (two's complement).
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             cp,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             x1,
  output logic             x2,
  output logic             y,
  input  logic             z,
  input  logic             ny
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_ss;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic             r_sub_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sub_in;
  logic             w_last;
  logic [WIDTH-1:0] w_ss_next;

`ifdef SERIAL_ADD_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_last    = (r_cnt == CNT_LAST);
  assign w_ss_next = {z, r_ss[WIDTH-1:1]};
  assign sum       = r_sum;
  assign cout      = r_cout;

  // State register
  always_ff @(posedge cp) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Adder-facing and status outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    x1   = 1'b0;
    x2   = 1'b0;
    y    = 1'b0;
    case (r_state)
      S_RUN: begin
        busy = 1'b1;
        x1   = r_sa[0];
        x2   = r_sb[0] ^ r_sub_q;
        y    = r_carry;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand shifters, carry state, sum collection
  always_ff @(posedge cp) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_ss    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_sub_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_ss    <= '0;
            r_carry <= w_sub_in;
            r_sub_q <= w_sub_in;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_ss    <= w_ss_next;
          r_carry <= ny;
          r_sa    <= r_sa >> 1;
          r_sb    <= r_sb >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum  <= w_ss_next;
            r_cout <= ny;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq with a behavioural full-adder model standing in for the external adder.
module tb_serial_add_seq;
  localparam int W = 8;

  logic         cp;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         x1;
  logic         x2;
  logic         y;
  logic         z;
  logic         ny;

  int n_checks;
  int n_err;

  serial_add_seq #(.WIDTH(W)) dut (
    .cp    (cp),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .x1    (x1),
    .x2    (x2),
    .y     (y),
    .z     (z),
    .ny    (ny)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // External adder: combinational sum, carry captured on the falling edge
  assign z = x1 ^ x2 ^ y;
  initial ny = 1'b0;
  always @(negedge cp) ny <= (x1 & x2) | (x1 & y) | (x2 & y);

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                       input logic isub);
    logic [W:0] bb;
    bb = {1'b0, (isub ? ~ib : ib)};
    return {1'b0, ia} + bb + {{W{1'b0}}, isub};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One operation via a single-cycle start pulse; lat counts cycles after the start cycle
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        output logic [W-1:0] osum, output logic ocout, output int lat,
                        output logic done_after,
                        output logic [W-1:0] sx1, output logic [W-1:0] sx2,
                        output logic [W-1:0] sy);
    @(posedge cp); #1;
    a = ia; b = ib; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = isub;
`endif
    @(posedge cp); #1;
    start = 1'b0;
    lat = 0; sx1 = '0; sx2 = '0; sy = '0;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge cp);
      if (n <= W) begin
        sx1[n-1] = x1; sx2[n-1] = x2; sy[n-1] = y;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    osum = sum; ocout = cout;
    @(negedge cp);
    done_after = done;
    if (isub) lat = lat;
  endtask

  vec_t         vecs[5];
  logic [W-1:0] r_sum_s, sx1, sx2, sy;
  logic         r_cout_s, dn_after;
  int           lat;
  logic [W:0]   exp;

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    repeat (2) @(posedge cp);
    #1 rst = 1'b0;
    @(negedge cp);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_xy", {29'd0, x1, x2, y}, 32'd0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, r_sum_s, r_cout_s, lat, dn_after, sx1, sx2, sy);
      chk($sformatf("tbl%0d_sum", i), 32'(r_sum_s), 32'(vecs[i].esum));
      chk($sformatf("tbl%0d_cout", i), 32'(r_cout_s), 32'(vecs[i].ecout));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("tbl%0d_done_width", i), 32'(dn_after), 32'd0);
      chk($sformatf("tbl%0d_x2_bits", i), 32'(sx2), 32'(vecs[i].vb));
      if (vecs[i].va == 8'hFF) begin
        chk("ff01_x1_seq", 32'(sx1), 32'hFF);
        chk("ff01_y_seq", 32'(sy), 32'hFE);
      end
    end

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, r_sum_s, r_cout_s, lat, dn_after, sx1, sx2, sy);
    chk("sub1_sum", 32'(r_sum_s), 32'h0F);
    chk("sub1_cout", 32'(r_cout_s), 32'd1);
    run_op(8'h01, 8'h02, 1'b1, r_sum_s, r_cout_s, lat, dn_after, sx1, sx2, sy);
    chk("sub2_sum", 32'(r_sum_s), 32'hFF);
    chk("sub2_cout", 32'(r_cout_s), 32'd0);
    sub = 1'b0;
`endif

    // Start pulse during RUN is ignored
    @(posedge cp); #1;
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge cp); #1;
    start = 1'b0; lat = 0;
    for (int n = 1; n <= W + 4; n++) begin
      @(negedge cp);
      if (n == 3) begin start = 1'b1; a = 8'h11; end
      if (n == 4) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    chk("ign_latency", 32'(lat), 32'(W + 1));
    chk("ign_sum", 32'(sum), 32'h96);
    chk("ign_cout", 32'(cout), 32'd0);
    @(negedge cp);
    chk("ign_no_queue1", 32'(busy), 32'd0);
    @(negedge cp);
    chk("ign_no_queue2", 32'(busy), 32'd0);

    // Reset four cycles into RUN
    @(posedge cp); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge cp); #1;
    start = 1'b0;
    repeat (3) @(posedge cp);
    #1 rst = 1'b1;
    @(posedge cp); #1 rst = 1'b0;
    @(negedge cp);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_sum", 32'(sum), 32'd0);
    chk("rst_mid_cout", 32'(cout), 32'd0);
    chk("rst_mid_xy", {29'd0, x1, x2, y}, 32'd0);
    run_op(8'h01, 8'h02, 1'b0, r_sum_s, r_cout_s, lat, dn_after, sx1, sx2, sy);
    chk("post_rst_sum", 32'(r_sum_s), 32'h03);
    chk("post_rst_latency", 32'(lat), 32'(W + 1));

    // Start held high: re-accepted on the first IDLE cycle
    begin
      int first, second;
      logic b1, b2;
      first = -1; second = -1; b1 = 1'b1; b2 = 1'b0;
      @(posedge cp); #1;
      a = 8'h21; b = 8'h43; start = 1'b1;
      for (int n = 1; n <= 3 * W; n++) begin
        @(negedge cp);
        if (first > 0 && n == first + 1) b1 = busy;
        if (first > 0 && n == first + 2) b2 = busy;
        if (done) begin
          if (first < 0) first = n;
          else if (second < 0) second = n;
        end
      end
      start = 1'b0;
      chk("held_first_latency", 32'(first), 32'(W + 2));
      chk("held_idle_gap", 32'(b1), 32'd0);
      chk("held_reaccept", 32'(b2), 32'd1);
      chk("held_period", 32'(second - first), 32'(W + 2));
      chk("held_sum", 32'(sum), 32'h64);
      repeat (W + 4) @(posedge cp);
    end

    // Randomised operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      exp = model(ra, rb, rs);
      run_op(ra, rb, rs, r_sum_s, r_cout_s, lat, dn_after, sx1, sx2, sy);
      chk($sformatf("rnd%0d_sum", i), 32'(r_sum_s), 32'(exp[W-1:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(r_cout_s), 32'(exp[W]));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("rnd%0d_x1_bits", i), 32'(sx1), 32'(ra));
      chk($sformatf("rnd%0d_sum_hold", i), 32'(sum), 32'(exp[W-1:0]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
